// File: rtl/reflet_int_scheduler.sv
// Serialising interrupt scheduler: captures request edges, arbitrates (fixed or
// round-robin), and runs a claim / EOI handshake with a claim timeout.
module reflet_int_scheduler #(
  parameter int unsigned wordsize       = 16,
  parameter int unsigned base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF10,
  parameter int unsigned claim_timeout  = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [7:0]                int_req,
  output logic [3:0]                cpu_int
);

  localparam int unsigned AW = base_addr_size + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SIGNAL, S_SERVICE} state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d, rr_q, rr_d, to_q, to_d;
  logic [1:0]  line_q, line_d;
  logic [7:0]  pend_q, pend_d, mask_q, mask_d, prev_q, prev_d, cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d, act_q, act_d;

  logic        sel, wr_ctrl, wr_pend, wr_act, wr_mask, abort;
  logic [1:0]  offset;
  logic [7:0]  wdata, rdata, sw_clr, grant_clr, repend, elig;
  logic [2:0]  start, win;
  logic        found;
  logic        unused_hi;

  // Address decode on a widened compare so base_addr+4 cannot wrap
  assign sel    = enable && ({1'b0, addr} >= {1'b0, base_addr})
                         && ({1'b0, addr} <  ({1'b0, base_addr} + AW'(4)));
  assign offset = 2'(addr - base_addr);
  assign wdata  = data_in[7:0];
  assign unused_hi = ^data_in[wordsize-1:8];

  assign wr_ctrl = sel && write_en && (offset == 2'd0);
  assign wr_pend = sel && write_en && (offset == 2'd1);
  assign wr_act  = sel && write_en && (offset == 2'd2);
  assign wr_mask = sel && write_en && (offset == 2'd3);
  assign abort   = wr_ctrl && !wdata[0];

  assign sw_clr = wr_pend ? wdata : 8'h00;

  // Eligibility seen by ARB includes software writes landing on the same edge
  assign elig  = pend_q & ~sw_clr & mask_d;
  assign start = rr_q ? ptr_q : 3'd0;

  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!found && elig[3'(start + 3'(k))]) begin
        found = 1'b1;
        win   = 3'(start + 3'(k));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    rr_d      = rr_q;
    line_d    = line_q;
    to_d      = to_q;
    mask_d    = wr_mask ? wdata : mask_q;
    prev_d    = int_req;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    act_d     = act_q;
    grant_clr = 8'h00;
    repend    = 8'h00;

    if (wr_ctrl) begin
      en_d   = wdata[0];
      rr_d   = wdata[1];
      line_d = wdata[3:2];
      if (wdata[7]) to_d = 1'b0;
    end

    if (abort) begin
      state_d = S_IDLE;
      act_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: if (en_q && |(pend_q & mask_q)) state_d = S_ARB;
        S_ARB: begin
          if (found) begin
            state_d   = S_SIGNAL;
            act_d     = win;
            grant_clr = 8'(1) << win;
            cnt_d     = 8'(claim_timeout);
            if (rr_q) ptr_d = 3'(win + 3'd1);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SIGNAL: begin
          cnt_d = 8'(cnt_q - 8'd1);
          if (wr_act) begin
            state_d = S_SERVICE;
          end else if (cnt_q == 8'd1) begin
            state_d = S_IDLE;
            repend  = 8'(1) << act_q;
            to_d    = 1'b1;
            act_d   = 3'd0;
          end
        end
        S_SERVICE: begin
          if (wr_act) begin
            state_d = S_IDLE;
            act_d   = 3'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // New edges win over any clear on the same edge
    pend_d = (pend_q & ~sw_clr & ~grant_clr) | repend | (int_req & ~prev_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      rr_q    <= 1'b0;
      line_q  <= 2'd0;
      to_q    <= 1'b0;
      pend_q  <= 8'h00;
      mask_q  <= 8'hFF;
      prev_q  <= 8'h00;
      cnt_q   <= 8'h00;
      ptr_q   <= 3'd0;
      act_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rr_q    <= rr_d;
      line_q  <= line_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    unique case (offset)
      2'd0:    rdata = {to_q, 3'b000, line_q, rr_q, en_q};
      2'd1:    rdata = pend_q;
      2'd2:    rdata = {(state_q == S_SIGNAL) || (state_q == S_SERVICE),
                        state_q == S_SERVICE, 3'b000, act_q};
      default: rdata = mask_q;
    endcase
  end

  assign data_out = sel ? wordsize'(rdata) : '0;
  assign cpu_int  = (state_q == S_SIGNAL) ? 4'(4'b0001 << line_q) : 4'b0000;

endmodule

// File: tb/tb_reflet_int_scheduler.sv
// Self-checking bench for reflet_int_scheduler: directed scenarios plus a
// randomized arbitration run against a transaction-level pending/pointer model.
module tb_reflet_int_scheduler;

  localparam logic [15:0] BASE = 16'hFF10;
  localparam int unsigned TO   = 4;

  logic        clk = 1'b0;
  logic        reset, enable, write_en;
  logic [15:0] addr, data_in, data_out;
  logic [7:0]  int_req;
  logic [3:0]  cpu_int;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  reflet_int_scheduler #(
    .wordsize(16), .base_addr_size(16), .base_addr(BASE), .claim_timeout(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .int_req(int_req), .cpu_int(cpu_int)
  );

  task automatic wr_raw(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = 16'(d);
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    wr_raw(BASE + 16'(off), d);
  endtask

  task automatic rd_raw(input logic [15:0] a, output logic [15:0] v);
    enable = 1'b1; write_en = 1'b0; addr = a;
    #1 v = data_out;
    enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [15:0] v);
    rd_raw(BASE + 16'(off), v);
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); int_req = v;
    @(negedge clk); int_req = 8'h00;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic claim_eoi();
    wr(2'd2, 8'h00);
    wr(2'd2, 8'h00);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0; enable = 1'b0; write_en = 1'b0; addr = 16'h0; data_in = 16'h0;
    int_req = 8'h02;
    #12;
    chk("reset cpu_int", 16'(cpu_int), 16'h0);
    rd(2'd0, v); chk("reset CTRL", v, 16'h0000);
    rd(2'd1, v); chk("reset PENDING", v, 16'h0000);
    rd(2'd2, v); chk("reset ACTIVE", v, 16'h0000);
    rd(2'd3, v); chk("reset MASK", v, 16'h00FF);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    rd(2'd1, v); chk("line high at release captured", v, 16'h0002);
    int_req = 8'h00;
    wr(2'd1, 8'hFF);
    rd(2'd1, v); chk("pending cleared", v, 16'h0000);
  endtask

  task automatic test_fixed();
    logic [15:0] v;
    wr(2'd0, 8'h01);
    pulse(8'h28);
    rd(2'd1, v); chk("fixed pending captured", v, 16'h0028);
    @(negedge clk); chk("fixed cpu_int in ARB", 16'(cpu_int), 16'h0);
    @(negedge clk); chk("fixed cpu_int SIGNAL", 16'(cpu_int), 16'h0001);
    rd(2'd2, v); chk("fixed ACTIVE signal", v, 16'h0083);
    wr(2'd2, 8'h00);
    chk("fixed cpu_int after claim", 16'(cpu_int), 16'h0);
    rd(2'd2, v); chk("fixed ACTIVE service", v, 16'h00C3);
    wr(2'd2, 8'h00);
    @(negedge clk); @(negedge clk);
    rd(2'd2, v); chk("fixed second grant", v, 16'h0085);
    chk("fixed second cpu_int", 16'(cpu_int), 16'h0001);
    claim_eoi();
  endtask

  task automatic test_round_robin();
    logic [15:0] v;
    wr(2'd0, 8'h03);
    for (int r = 0; r < 2; r++) begin
      pulse(8'h81);
      @(negedge clk); @(negedge clk);
      rd(2'd2, v); chk("rr first grant", v, 16'h0080);
      claim_eoi();
      @(negedge clk); @(negedge clk);
      rd(2'd2, v); chk("rr second grant", v, 16'h0087);
      claim_eoi();
    end
  endtask

  task automatic test_mask_w1c();
    logic [15:0] v;
    wr(2'd0, 8'h01);
    wr(2'd3, 8'hFE);
    pulse(8'h01);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("masked cpu_int", 16'(cpu_int), 16'h0);
    rd(2'd1, v); chk("masked pending", v, 16'h0001);
    wr(2'd1, 8'h01);
    rd(2'd1, v); chk("w1c pending", v, 16'h0000);
    @(negedge clk);
    int_req = 8'h01;
    enable = 1'b1; write_en = 1'b1; addr = BASE + 16'd1; data_in = 16'h0001;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; int_req = 8'h00;
    rd(2'd1, v); chk("set beats clear", v, 16'h0001);
    wr(2'd1, 8'h01);
    wr(2'd3, 8'hFF);
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    wr(2'd0, 8'h09);
    pulse(8'h08);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < int'(TO); i++) begin
      if (i > 0) @(negedge clk);
      chk("timeout cpu_int high", 16'(cpu_int), 16'h0004);
    end
    @(negedge clk);
    chk("timeout cpu_int dropped", 16'(cpu_int), 16'h0);
    rd(2'd1, v); chk("timeout repend", v, 16'h0008);
    rd(2'd0, v); chk("timeout TO flag", v, 16'h0089);
    wr(2'd0, 8'h89);
    rd(2'd0, v); chk("TO cleared", v, 16'h0009);
    chk("regrant cpu_int", 16'(cpu_int), 16'h0004);
    rd(2'd2, v); chk("regrant ACTIVE", v, 16'h0083);
    claim_eoi();
  endtask

  task automatic test_abort_reset();
    logic [15:0] v;
    wr(2'd0, 8'h01);
    pulse(8'h04);
    @(negedge clk); @(negedge clk);
    wr(2'd2, 8'h00);
    rd(2'd2, v); chk("abort in SERVICE", v, 16'h00C2);
    wr(2'd0, 8'h00);
    rd(2'd2, v); chk("abort ACTIVE", v, 16'h0000);
    rd(2'd1, v); chk("abort no repend", v, 16'h0000);
    wr(2'd3, 8'h7F);
    wr(2'd0, 8'h01);
    pulse(8'h10);
    @(negedge clk); @(negedge clk);
    chk("pre-reset cpu_int", 16'(cpu_int), 16'h0001);
    #2 reset = 1'b0;
    #1 chk("reset drops cpu_int", 16'(cpu_int), 16'h0);
    rd(2'd3, v); chk("reset MASK", v, 16'h00FF);
    @(negedge clk); reset = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_decode();
    logic [15:0] v;
    wr(2'd0, 8'h02);
    wr(2'd3, 8'h5A);
    rd_raw(BASE + 16'd4, v); chk("read base+4", v, 16'h0000);
    rd_raw(BASE - 16'd1, v); chk("read base-1", v, 16'h0000);
    wr_raw(BASE + 16'd4, 8'h00);
    wr_raw(BASE - 16'd1, 8'h00);
    rd(2'd0, v); chk("CTRL untouched", v, 16'h0002);
    rd(2'd3, v); chk("MASK untouched", v, 16'h005A);
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [7:0]  mask, req, m_pend;
    int rr, line, idx, n;
    m_pend = 8'h00;
    for (int it = 0; it < 20; it++) begin
      rr = int'($urandom_range(0, 1));
      line = int'($urandom_range(0, 3));
      mask = 8'($urandom);
      req  = 8'($urandom);
      wr(2'd0, 8'(8'h01 | (rr << 1) | (line << 2)));
      wr(2'd3, mask);
      pulse(req);
      m_pend = m_pend | req;
      while ((m_pend & mask) != 8'h00) begin
        n = 0;
        while (cpu_int == 4'h0 && n < 12) begin
          @(negedge clk);
          n++;
        end
        if (cpu_int == 4'h0) begin
          total++; bad++;
          $display("FAIL random grant wait: cpu_int stayed 0, pending model %h", m_pend);
          break;
        end
        idx = -1;
        for (int k = 0; k < 8; k++) begin
          int j;
          j = ((rr != 0 ? m_ptr : 0) + k) % 8;
          if (idx < 0 && m_pend[j] && mask[j]) idx = j;
        end
        chk("random cpu_int line", 16'(cpu_int), 16'(1 << line));
        rd(2'd2, v); chk("random ACTIVE", v, 16'(8'h80 | idx));
        m_pend[idx] = 1'b0;
        if (rr != 0) m_ptr = (idx + 1) % 8;
        claim_eoi();
      end
      rd(2'd1, v); chk("random leftover pending", v, 16'(m_pend));
      wr(2'd1, 8'hFF);
      m_pend = 8'h00;
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_mask_w1c();
    test_timeout();
    test_abort_reset();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
